// File: rtl/ip_addr_filter_pkg.sv
// Shared derivations and the per-entry record for the IP address filter.
package ip_addr_filter_pkg;

    // Width of the stored entry record; the top-level ADDR_W defaults to this.
    localparam int unsigned REC_ADDR_W = 32;

    function automatic int unsigned calc_beats(input int unsigned addr_w, input int unsigned data_w);
        return addr_w / data_w;
    endfunction

    function automatic int unsigned calc_ent_w(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    typedef struct packed {
        logic [REC_ADDR_W-1:0] addr;
        logic [REC_ADDR_W-1:0] mask;
        logic                  en;
    } entry_t;

endpackage

// File: rtl/ip_addr_filter_entry.sv
// One filter entry: programmable address/mask, per-beat slice compare and
// the per-packet running match flag.
module ip_addr_filter_entry
    import ip_addr_filter_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = REC_ADDR_W,
    parameter int BEATS  = calc_beats(ADDR_W, DATA_W)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              wr_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [ADDR_W-1:0] cfg_mask_i,
    input  logic              cfg_en_i,
    input  logic              idle_i,
    input  logic              beat_v_i,
    input  logic [BEATS-1:0]  beat_sel_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic              last_i,
    input  logic              seen_ok_i,
    output logic              hit_o
);

    entry_t           entry_q, entry_d;
    logic             run_q, run_d;
    logic [BEATS-1:0] slice_ok;
    logic             cur_ok;

    // Slice 0 is the most significant DATA_W bits of the address.
    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_slice
            assign slice_ok[gi] =
                (((data_i ^ entry_q.addr[ADDR_W-1-gi*DATA_W -: DATA_W])
                  & entry_q.mask[ADDR_W-1-gi*DATA_W -: DATA_W]) == '0);
        end
    endgenerate

    assign cur_ok = |(slice_ok & beat_sel_i);

    always_comb begin
        entry_d = entry_q;
        run_d   = run_q;
        if (wr_i) begin
            entry_d.addr = cfg_addr_i;
            entry_d.mask = cfg_mask_i;
            entry_d.en   = cfg_en_i;
        end
        // A rewrite drops the entry from the packet already in flight.
        if (idle_i) begin
            run_d = 1'b1;
        end else if (wr_i) begin
            run_d = 1'b0;
        end else if (beat_v_i && !cur_ok) begin
            run_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            entry_q <= '0;
            run_q   <= 1'b1;
        end else begin
            entry_q <= entry_d;
            run_q   <= run_d;
        end
    end

    assign hit_o = entry_q.en & run_q & cur_ok & last_i & seen_ok_i;

endmodule

// File: rtl/ip_addr_filter.sv
// IP address filter: compares header beats against N_ADDR programmable
// address/mask entries and reports the lowest matching entry.
module ip_addr_filter
    import ip_addr_filter_pkg::*;
#(
    parameter  int DATA_W    = 16,
    parameter  int ADDR_W    = REC_ADDR_W,
    parameter  int IDX_W     = 5,
    parameter  int START_IDX = 6,
    parameter  int N_ADDR    = 4,
    localparam int BEATS     = calc_beats(ADDR_W, DATA_W),
    localparam int ENT_W     = calc_ent_w(N_ADDR)
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              valid_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [IDX_W-1:0]  idx_i,
    input  logic              fsm_idle_v_i,
    input  logic              fsm_head_v_i,
    input  logic              cfg_wr_v_i,
    input  logic [ENT_W-1:0]  cfg_idx_i,
    input  logic [ADDR_W-1:0] cfg_addr_i,
    input  logic [ADDR_W-1:0] cfg_mask_i,
    input  logic              cfg_en_i,
    output logic              match_fail_v_o,
    output logic              match_v_o,
    output logic              match_hit_o,
    output logic [ENT_W-1:0]  match_idx_o
);

    localparam logic [BEATS-1:0] LAST_BIT = BEATS'(1) << (BEATS - 1);

    logic [BEATS-1:0]  beat_sel;
    logic [BEATS-1:0]  seen_q, seen_d;
    logic [N_ADDR-1:0] hits;
    logic              accept, last, seen_ok, any_hit;
    logic [ENT_W-1:0]  hit_idx;
    logic              match_v_q, match_hit_q;
    logic [ENT_W-1:0]  match_idx_q;

    generate
        for (genvar gi = 0; gi < BEATS; gi++) begin : g_sel
            assign beat_sel[gi] = (idx_i == IDX_W'(START_IDX + gi));
        end
    endgenerate

    assign accept  = valid_i & ~fsm_idle_v_i & (|beat_sel);
    assign last    = accept & beat_sel[BEATS-1];
    // The last beat itself need not have been seen earlier.
    assign seen_ok = &(seen_q | LAST_BIT);

    generate
        for (genvar gi = 0; gi < N_ADDR; gi++) begin : g_ent
            ip_addr_filter_entry #(
                .DATA_W (DATA_W),
                .ADDR_W (ADDR_W),
                .BEATS  (BEATS)
            ) u_entry (
                .clk        (clk),
                .nreset     (nreset),
                .wr_i       (cfg_wr_v_i && (cfg_idx_i == ENT_W'(gi))),
                .cfg_addr_i (cfg_addr_i),
                .cfg_mask_i (cfg_mask_i),
                .cfg_en_i   (cfg_en_i),
                .idle_i     (fsm_idle_v_i),
                .beat_v_i   (accept),
                .beat_sel_i (beat_sel),
                .data_i     (data_i),
                .last_i     (last),
                .seen_ok_i  (seen_ok),
                .hit_o      (hits[gi])
            );
        end
    endgenerate

    assign any_hit = |hits;

    always_comb begin
        hit_idx = '0;
        for (int i = N_ADDR - 1; i >= 0; i--) begin
            if (hits[i]) hit_idx = ENT_W'(i);
        end
    end

    always_comb begin
        seen_d = seen_q;
        if (fsm_idle_v_i) begin
            seen_d = '0;
        end else if (accept) begin
            seen_d = seen_q | beat_sel;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            seen_q      <= '0;
            match_v_q   <= 1'b0;
            match_hit_q <= 1'b0;
            match_idx_q <= '0;
        end else begin
            seen_q      <= seen_d;
            match_v_q   <= last;
            match_hit_q <= last & any_hit;
            match_idx_q <= last ? hit_idx : '0;
        end
    end

    assign match_fail_v_o = fsm_head_v_i & last & ~any_hit;
    assign match_v_o      = match_v_q;
    assign match_hit_o    = match_hit_q;
    assign match_idx_o    = match_idx_q;

endmodule

// File: tb/tb_ip_addr_filter.sv
// Directed bench for ip_addr_filter with hand-computed expected decisions.
module tb_ip_addr_filter;

    logic        clk = 1'b0;
    logic        nreset;
    logic        valid_i;
    logic [15:0] data_i;
    logic [4:0]  idx_i;
    logic        fsm_idle_v_i;
    logic        fsm_head_v_i;
    logic        cfg_wr_v_i;
    logic [1:0]  cfg_idx_i;
    logic [31:0] cfg_addr_i;
    logic [31:0] cfg_mask_i;
    logic        cfg_en_i;
    logic        match_fail_v_o;
    logic        match_v_o;
    logic        match_hit_o;
    logic [1:0]  match_idx_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ip_addr_filter #(
        .DATA_W    (16),
        .ADDR_W    (32),
        .IDX_W     (5),
        .START_IDX (6),
        .N_ADDR    (4)
    ) dut (
        .clk            (clk),
        .nreset         (nreset),
        .valid_i        (valid_i),
        .data_i         (data_i),
        .idx_i          (idx_i),
        .fsm_idle_v_i   (fsm_idle_v_i),
        .fsm_head_v_i   (fsm_head_v_i),
        .cfg_wr_v_i     (cfg_wr_v_i),
        .cfg_idx_i      (cfg_idx_i),
        .cfg_addr_i     (cfg_addr_i),
        .cfg_mask_i     (cfg_mask_i),
        .cfg_en_i       (cfg_en_i),
        .match_fail_v_o (match_fail_v_o),
        .match_v_o      (match_v_o),
        .match_hit_o    (match_hit_o),
        .match_idx_o    (match_idx_o)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
            $display("ok   %s obs=%0h exp=%0h", tag, obs, exp);
        end else begin
            $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    // All tasks start and end at posedge+1 with strobes deasserted.
    task automatic idle_cycle();
        fsm_idle_v_i = 1'b1;
        @(posedge clk); #1;
        fsm_idle_v_i = 1'b0;
    endtask

    task automatic cfg_write(input logic [1:0] e, input logic [31:0] a,
                             input logic [31:0] m, input logic en);
        cfg_wr_v_i = 1'b1; cfg_idx_i = e; cfg_addr_i = a; cfg_mask_i = m; cfg_en_i = en;
        @(posedge clk); #1;
        cfg_wr_v_i = 1'b0;
    endtask

    task automatic send_beat(input string tag, input logic [4:0] idx,
                             input logic [15:0] d, input logic exp_fail);
        valid_i = 1'b1; idx_i = idx; data_i = d;
        #2;
        check({tag, ".fail"}, 32'(match_fail_v_o), 32'(exp_fail));
        @(posedge clk); #1;
        valid_i = 1'b0;
    endtask

    task automatic check_dec(input string tag, input logic v, input logic hit, input logic [1:0] idx);
        check({tag, ".v"},   32'(match_v_o),   32'(v));
        check({tag, ".hit"}, 32'(match_hit_o), 32'(hit));
        check({tag, ".idx"}, 32'(match_idx_o), 32'(idx));
    endtask

    task automatic packet(input string tag, input logic [15:0] d6, input logic [15:0] d7,
                          input logic exp_fail, input logic exp_hit, input logic [1:0] exp_idx);
        idle_cycle();
        send_beat({tag, ".b6"}, 5'd6, d6, 1'b0);
        send_beat({tag, ".b7"}, 5'd7, d7, exp_fail);
        check_dec(tag, 1'b1, exp_hit, exp_idx);
    endtask

    initial begin
        nreset = 1'b0; valid_i = 1'b0; data_i = '0; idx_i = '0;
        fsm_idle_v_i = 1'b0; fsm_head_v_i = 1'b0; cfg_wr_v_i = 1'b0;
        cfg_idx_i = '0; cfg_addr_i = '0; cfg_mask_i = '0; cfg_en_i = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        check_dec("reset", 1'b0, 1'b0, 2'd0);
        check("reset.fail", 32'(match_fail_v_o), 32'd0);
        nreset = 1'b1;
        @(posedge clk); #1;
        fsm_head_v_i = 1'b1;

        // Exact match on entry 2, then last-slice mismatch.
        cfg_write(2'd2, 32'hCEC87F80, 32'hFFFFFFFF, 1'b1);
        idle_cycle();
        send_beat("exact.b6", 5'd6, 16'hCEC8, 1'b0);
        check("exact.b6.v", 32'(match_v_o), 32'd0);
        send_beat("exact.b7", 5'd7, 16'h7F80, 1'b0);
        check_dec("exact", 1'b1, 1'b1, 2'd2);
        packet("miss", 16'hCEC8, 16'h7F81, 1'b1, 1'b0, 2'd0);

        // Lowest matching index wins.
        cfg_write(2'd1, 32'hCEC80000, 32'hFFFF0000, 1'b1);
        cfg_write(2'd3, 32'hCEC80000, 32'hFFFF0000, 1'b1);
        packet("prio", 16'hCEC8, 16'h7F80, 1'b0, 1'b1, 2'd1);

        // Last beat without the first beat seen.
        idle_cycle();
        send_beat("nob6.b7", 5'd7, 16'h7F80, 1'b1);
        check_dec("nob6", 1'b1, 1'b0, 2'd0);

        // Rewrite mid-packet drops the entry for that packet only.
        cfg_write(2'd1, 32'hCEC80000, 32'hFFFF0000, 1'b0);
        cfg_write(2'd3, 32'hCEC80000, 32'hFFFF0000, 1'b0);
        idle_cycle();
        send_beat("rewr.b6", 5'd6, 16'hCEC8, 1'b0);
        cfg_write(2'd2, 32'hCEC87F80, 32'hFFFFFFFF, 1'b1);
        send_beat("rewr.b7", 5'd7, 16'h7F80, 1'b1);
        check_dec("rewr", 1'b1, 1'b0, 2'd0);
        packet("after_rewr", 16'hCEC8, 16'h7F80, 1'b0, 1'b1, 2'd2);

        // Repeated first beat: equal data keeps the match, differing data kills it.
        idle_cycle();
        send_beat("rep_eq.b6a", 5'd6, 16'hCEC8, 1'b0);
        send_beat("rep_eq.b6b", 5'd6, 16'hCEC8, 1'b0);
        send_beat("rep_eq.b7", 5'd7, 16'h7F80, 1'b0);
        check_dec("rep_eq", 1'b1, 1'b1, 2'd2);
        idle_cycle();
        send_beat("rep_ne.b6a", 5'd6, 16'hCEC8, 1'b0);
        send_beat("rep_ne.b6b", 5'd6, 16'hCEC9, 1'b0);
        send_beat("rep_ne.b7", 5'd7, 16'h7F80, 1'b1);
        check_dec("rep_ne", 1'b1, 1'b0, 2'd0);

        // Ignored index does not disturb the packet.
        idle_cycle();
        send_beat("ign.b6", 5'd6, 16'hCEC8, 1'b0);
        send_beat("ign.b9", 5'd9, 16'h1234, 1'b0);
        send_beat("ign.b7", 5'd7, 16'h7F80, 1'b0);
        check_dec("ign", 1'b1, 1'b1, 2'd2);

        // Fail output only in header state.
        fsm_head_v_i = 1'b0;
        packet("nohead", 16'hCEC8, 16'h7F81, 1'b0, 1'b0, 2'd0);
        fsm_head_v_i = 1'b1;

        // Idle together with a last beat discards the beat.
        idle_cycle();
        send_beat("idlewin.b6", 5'd6, 16'hCEC8, 1'b0);
        fsm_idle_v_i = 1'b1;
        send_beat("idlewin.b7", 5'd7, 16'h7F80, 1'b0);
        fsm_idle_v_i = 1'b0;
        check("idlewin.v", 32'(match_v_o), 32'd0);

        // Reset mid-header abandons the packet and clears the table.
        idle_cycle();
        send_beat("rst.b6", 5'd6, 16'hCEC8, 1'b0);
        nreset = 1'b0;
        #2;
        check_dec("rst.during", 1'b0, 1'b0, 2'd0);
        #2;
        nreset = 1'b1;
        @(posedge clk); #1;
        check("rst.nopulse", 32'(match_v_o), 32'd0);
        cfg_write(2'd2, 32'hCEC87F80, 32'hFFFFFFFF, 1'b1);
        send_beat("rst.b7", 5'd7, 16'h7F80, 1'b1);
        check_dec("rst.after", 1'b1, 1'b0, 2'd0);

        // Empty table always fails.
        nreset = 1'b0;
        #2;
        nreset = 1'b1;
        @(posedge clk); #1;
        packet("empty", 16'hCEC8, 16'h7F80, 1'b1, 1'b0, 2'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout obs=running exp=finished");
        $fatal(1);
    end

endmodule
